// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_t        - receiver FSM state encoding
//   START_LVL/STOP_LVL/IDLE_LVL - serial line levels of the frame fields
//   DEFAULT_DATA_BITS - default word width
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam int unsigned DEFAULT_DATA_BITS = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous single-bit input.
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset; both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output (two cycles of latency)
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver. Frame = start(0), DATA_BITS data LSB first,
// one parity bit, one stop(1). Samples at bit centres using a half-bit
// offset taken during the start bit.
//   i_clk        - system clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_rxd        - asynchronous serial input, idle high
//   o_data       - last received word, held until the next frame completes
//   o_valid      - one-cycle pulse when o_data updates
//   o_frame_err  - one-cycle pulse with o_valid when the stop bit was low
//   o_parity_err - one-cycle pulse with o_valid on even-parity mismatch
//   o_busy       - high whenever the FSM is not in IDLE
// Build option: define UART_RX_PARITY_CHECK_EN to enable parity checking;
// otherwise the parity bit is skipped and o_parity_err is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state_q;
  logic [CNT_W-1:0]     clk_cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 cnt_last;
`ifdef UART_RX_PARITY_CHECK_EN
  logic                 par_q;
  logic                 perr_q;
`endif

  uart_rx_sync #(
    .RESET_VAL(IDLE_LVL)
  ) u_sync (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .d_i  (i_rxd),
    .q_o  (rxd_s)
  );

  assign cnt_last = (clk_cnt_q == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (rxd_s == START_LVL) state_q <= START;
        end
        START: begin
          if (clk_cnt_q == CNT_HALF) begin
            clk_cnt_q <= '0;
            // Start bit still low at its centre: real frame, else a glitch.
            if (rxd_s == START_LVL) begin
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            clk_cnt_q <= '0;
            shift_q   <= {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_LAST) state_q <= PARITY;
            else bit_idx_q <= bit_idx_q + IDX_W'(1);
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt_last) begin
            clk_cnt_q <= '0;
`ifdef UART_RX_PARITY_CHECK_EN
            par_q     <= rxd_s;
`endif
            state_q   <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            clk_cnt_q <= '0;
            // Word is delivered even on a bad stop bit; flags tell the consumer.
            data_q    <= shift_q;
            valid_q   <= 1'b1;
            ferr_q    <= (rxd_s != STOP_LVL);
`ifdef UART_RX_PARITY_CHECK_EN
            perr_q    <= (par_q != ^shift_q);
`endif
            state_q   <= (rxd_s == STOP_LVL) ? IDLE : BREAK;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // cannot be mistaken for a stream of start bits.
          clk_cnt_q <= '0;
          if (rxd_s == IDLE_LVL) state_q <= IDLE;
        end
        default: begin
          clk_cnt_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_CHECK_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
